// File: rtl/sm83_mcycle_ctrl.sv
// SM83 machine-cycle controller: T-state/M-cycle counters, bus handshake with wait
// states, address latch with IDU, and HALT/wake. The HALT state is visible on `halted`.
module sm83_mcycle_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int T_PER_M = 4,
  parameter int MAX_M = 6,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic                       req_rd,
  input  logic                       req_wr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [1:0]                 req_idu,
  input  logic                       req_last,
  input  logic                       halt_req,
  input  logic                       wake,
  input  logic                       mem_ready,
  input  logic [DATA_W-1:0]          d_in,
  output logic [ADDR_W-1:0]          addr,
  output logic [DATA_W-1:0]          d_out,
  output logic                       read,
  output logic                       write,
  output logic [DATA_W-1:0]          rdata,
  output logic [ADDR_W-1:0]          idu_out,
  output logic [$clog2(T_PER_M)-1:0] t_idx,
  output logic [$clog2(MAX_M)-1:0]   m_idx,
  output logic                       m_end,
  output logic                       halted,
  output logic                       err
);

  localparam int TW = $clog2(T_PER_M);
  localparam int MW = $clog2(MAX_M);
  localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);
  localparam logic [MW-1:0] M_LAST = MW'(MAX_M - 1);

  typedef enum logic {RUN, HALT} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       t_q, t_d;
  logic [MW-1:0]       m_q, m_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   idu_q, idu_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                m_end_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      t_q     <= '0;
      m_q     <= '0;
      addr_q  <= RESET_ADDR;
      idu_q   <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      m_q     <= m_d;
      addr_q  <= addr_d;
      idu_q   <= idu_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    m_d     = m_q;
    addr_d  = addr_q;
    idu_d   = idu_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    read_d  = read_q;
    write_d = write_q;
    last_d  = last_q;
    err_d   = err_q;
    // Bus handshake: an active strobe completes in the last T-state only when mem_ready is high.
    m_end_c = (state_q == RUN) && (t_q == T_LAST) && (!(read_q || write_q) || mem_ready);
    case (state_q)
      RUN: begin
        if (t_q == '0) begin
          addr_d  = req_addr;
          dout_d  = req_wdata;
          read_d  = req_rd & ~req_wr;
          write_d = req_wr;
          last_d  = req_last;
          case (req_idu)
            2'd0:    idu_d = req_addr + ADDR_W'(1);
            2'd1:    idu_d = req_addr - ADDR_W'(1);
            default: idu_d = req_addr;
          endcase
          if (req_rd && req_wr) err_d = 1'b1;
          t_d = TW'(1);
        end else if (t_q != T_LAST) begin
          t_d = t_q + TW'(1);
        end else if (m_end_c) begin
          if (read_q) rdata_d = d_in;
          read_d  = 1'b0;
          write_d = 1'b0;
          t_d     = '0;
          if (last_q) begin
            m_d = '0;
          end else if (m_q == M_LAST) begin
            m_d   = '0;
            err_d = 1'b1;
          end else begin
            m_d = m_q + MW'(1);
          end
          // A simultaneous wake cancels the halt request.
          if (last_q && halt_req && !wake) state_d = HALT;
        end
      end
      HALT: begin
        if (wake) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign addr    = addr_q;
  assign d_out   = dout_q;
  assign read    = read_q;
  assign write   = write_q;
  assign rdata   = rdata_q;
  assign idu_out = idu_q;
  assign t_idx   = t_q;
  assign m_idx   = m_q;
  assign m_end   = m_end_c;
  assign halted  = (state_q == HALT);
  assign err     = err_q;

endmodule

// File: doc/sm83_mcycle_ctrl.md
# sm83_mcycle_ctrl

Parametrised machine-cycle controller for the SM83 core. It sits between the instruction decoder and external memory, and owns three pieces of timing:
- the T-state/M-cycle counters that the decoder indexes its micro-steps by (generalising the fixed M1/M2/M3 sequence);
- the memory bus handshake, with wait states;
- the address latch plus IDU increment/decrement.

It adds configurable T-states per M-cycle, a configurable maximum instruction length, wait-state stalling, HALT/wake, and error flagging.

## Interface
Parameters:
- ADDR_W, 16, address and IDU width.
- DATA_W, 8, data bus width.
- T_PER_M, 4, T-states (clocks) per M-cycle. Legal range is 2 or more.
- MAX_M, 6, maximum M-cycles per instruction. Legal range is 2 or more.
- RESET_ADDR, 0, value of `addr` at reset.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_addr  in  ADDR_W  address for this M-cycle; sampled at end of T0.
- req_rd  in  1  memory read this M-cycle; sampled at end of T0.
- req_wr  in  1  memory write this M-cycle; sampled at end of T0.
- req_wdata  in  DATA_W  write data; sampled at end of T0.
- req_idu  in  2  IDU op: 0=INC, 1=DEC, 2/3=NONE (pass-through); sampled at end of T0.
- req_last  in  1  this M-cycle ends the instruction; sampled at end of T0.
- halt_req  in  1  enter HALT after the current instruction.
- wake  in  1  leave HALT.
- mem_ready  in  1  memory completes access this clock.
- d_in  in  DATA_W  memory read data.
- addr  out  ADDR_W  bus address.
- d_out  out  DATA_W  bus write data.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- rdata  out  DATA_W  last captured read data.
- idu_out  out  ADDR_W  latched address ±1 per req_idu.
- t_idx  out  $clog2(T_PER_M)  current T-state.
- m_idx  out  $clog2(MAX_M)  current M-cycle within instruction; 0 = M1 (fetch).
- m_end  out  1  combinational; high in the final clock of an M-cycle.
- halted  out  1  controller is in HALT.
- err  out  1  sticky error flag.

## Operation
States:
- RUN.
- HALT.

Reset (rst=1 at an edge):
- t_idx=0, m_idx=0, state=RUN.
- addr=RESET_ADDR; d_out=0, read=0, write=0, rdata=0, idu_out=0, halted=0, err=0.
- The first clock after rst deasserts is T0 of M-cycle 0.
- rst asserted mid-access aborts the access immediately: no rdata capture, strobes drop at that edge.

T0 (decode phase):
- The decoder drives req_* combinationally from m_idx.
- read and write are low.
- The edge ending T0 latches the request:
  - addr←req_addr, d_out←req_wdata.
  - read←req_rd&~req_wr, write←req_wr.
  - idu_out←req_addr+1, req_addr−1 or req_addr, per req_idu. Arithmetic is modulo 2^ADDR_W, so FFFF+1=0000 and 0000−1=FFFF.

T1..T_PER_M−1 (bus phase):
- addr, d_out, read and write are held stable.

Wait states:
- In the last T-state, if (read|write) & ~mem_ready, t_idx holds and m_end=0.
- Stalling is unbounded.

M-cycle completion:
- m_end = (t_idx==T_PER_M−1) & (~(read|write) | mem_ready).
- On the m_end edge:
  - If read, rdata←d_in.
  - read and write clear; t_idx←0.
  - If req_last was latched, m_idx←0, else m_idx←m_idx+1.
- addr and idu_out hold their values until the next end of T0.

Errors:
- req_rd & req_wr together sets err, performs the write only, and suppresses the read.
- Reaching m_idx=MAX_M−1 without req_last latched sets err and forces m_idx←0 at that cycle's m_end.
- err clears only on rst.

HALT:
- Entry: halt_req high at an m_end edge whose latched req_last=1 → state HALT, halted=1, t_idx=0, m_idx=0.
- In HALT: no latching, strobes low.
- Exit: wake high at an edge → RUN; the next clock is T0 of M1.
- wake and halt_req in the same edge: halt_req is ignored (stay RUN).

## Timing
- Unstalled M-cycle length is exactly T_PER_M clocks; each wait clock adds 1.
- Request to strobe latency: req_* sampled at end of T0; strobes are valid from T1.
- idu_out is valid from T1 through the next T0. It is intended for the decoder's register writeback at m_end.
- rdata is valid from the clock after m_end and holds until the next read completes.
- m_end is combinational from registered state and mem_ready. It has no combinational path from req_*.

## Test plan
Unless stated otherwise, T_PER_M=4 and MAX_M=6.
- Reset, then a read: after rst, drive req_addr=0x0100, req_rd=1, req_idu=INC, req_last=1, with mem_ready=1 and d_in=0x3E → read high T1–T3, addr=0x0100, idu_out=0x0101, m_end in T3, rdata=0x3E from the next clock, m_idx back to 0.
- Three-cycle instruction: fetch, read 0x0101, then write 0xC000←0x55 with req_last on cycle 3 → m_idx sequence 0,1,2,0; write high only in T1–T3 of cycle 2; d_out=0x55; 12 clocks total.
- Wait states: mem_ready low for 3 clocks in T3 → t_idx holds at 3, strobes and addr stable, m_end asserts on the 4th clock, M-cycle length 7.
- IDU wrap and errors: req_addr=0xFFFF with INC → idu_out=0x0000. req_addr=0x0000 with DEC → 0xFFFF. req_rd=req_wr=1 → write only, err=1. Six M-cycles with no req_last → err=1, m_idx wraps to 0.
- HALT: halt_req at the last m_end → halted=1, no strobes for 10 clocks; wake → T0 of M1 next clock. Also check halt_req and wake on the same edge → no HALT.
- Reset mid-access: rst in T2 of a read → read=0, rdata unchanged, t_idx=m_idx=0, addr=RESET_ADDR. Repeat the first scenario with T_PER_M=2 → 2-clock M-cycles.
